// File: rtl/exe_div_ctrl.sv
// exe_div_ctrl: iterative restoring divider for the EXE stage (DIV / DIVU).
//   One quotient bit per cycle, MSB first; WIDTH BUSY cycles per divide.
//   Ports:
//     clk, resetn                    clock, async active-low reset
//     EXE_DivStart, EXE_DivSigned    request + mode, sampled in IDLE only
//     EXE_ResultA, EXE_ResultB       dividend / divisor
//     EXE_Flush                      abort anything in flight
//     EXE_DivAck                     consumer took the result
//     EXE_DivStall                   combinational pipeline stall
//     EXE_DivValid                   result registers hold a valid result
//     EXE_DivQuotient / Remainder    LO / HI write data
module exe_div_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             EXE_DivStart,
  input  logic             EXE_DivSigned,
  input  logic [WIDTH-1:0] EXE_ResultA,
  input  logic [WIDTH-1:0] EXE_ResultB,
  input  logic             EXE_Flush,
  input  logic             EXE_DivAck,
  output logic             EXE_DivStall,
  output logic             EXE_DivValid,
  output logic [WIDTH-1:0] EXE_DivQuotient,
  output logic [WIDTH-1:0] EXE_DivRemainder
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;   // dividend magnitude; quotient bits shift in at LSB
  logic [WIDTH-1:0] dvs_q, dvs_d;   // divisor magnitude
  logic [WIDTH-1:0] rem_q, rem_d;   // partial remainder (always < divisor)
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   rem_sh;         // shifted remainder needs one extra bit
  logic             ge;
  logic [WIDTH-1:0] rem_nx, q_nx;

  always_comb begin
    a_neg = EXE_DivSigned & EXE_ResultA[WIDTH-1];
    b_neg = EXE_DivSigned & EXE_ResultB[WIDTH-1];
    // Negating 0x80..0 yields 0x80..0, which is the correct unsigned magnitude.
    a_mag = a_neg ? -EXE_ResultA : EXE_ResultA;
    b_mag = b_neg ? -EXE_ResultB : EXE_ResultB;

    rem_sh = {rem_q, dvd_q[WIDTH-1]};
    ge     = rem_sh >= {1'b0, dvs_q};
    // When ge=0 the shifted value is below the divisor, so it fits WIDTH bits.
    rem_nx = ge ? WIDTH'(rem_sh - {1'b0, dvs_q}) : rem_sh[WIDTH-1:0];
    q_nx   = {dvd_q[WIDTH-2:0], ge};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;

    if (EXE_Flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (EXE_DivStart) begin
          dvd_d  = a_mag;
          dvs_d  = b_mag;
          rem_d  = '0;
          cnt_d  = '0;
          negq_d = a_neg ^ b_neg;
          negr_d = a_neg;
          if (EXE_ResultB == '0) begin
            // Divide-by-zero skips the iteration; dividend is returned raw.
            quo_d   = '1;
            rmd_d   = EXE_ResultA;
            state_d = S_DONE;
          end else begin
            state_d = S_BUSY;
          end
        end
        S_BUSY: begin
          rem_d = rem_nx;
          dvd_d = q_nx;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            quo_d   = negq_q ? -q_nx : q_nx;
            rmd_d   = negr_q ? -rem_nx : rem_nx;
            state_d = S_DONE;
          end
        end
        S_DONE: if (EXE_DivAck) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      quo_q   <= '0;
      rmd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
    end
  end

  // Flush releases the pipeline in the same cycle; reset forces stall low
  // even if a start is presented while the state is held in IDLE.
  assign EXE_DivStall = resetn & ~EXE_Flush &
                        (((state_q == S_IDLE) & EXE_DivStart) |
                         (state_q == S_BUSY) |
                         ((state_q == S_DONE) & ~EXE_DivAck));

  assign EXE_DivValid     = (state_q == S_DONE);
  assign EXE_DivQuotient  = quo_q;
  assign EXE_DivRemainder = rmd_q;

endmodule

// File: tb/tb_exe_div_ctrl.sv
module tb_exe_div_ctrl;
  logic        clk = 1'b0;
  logic        resetn;
  logic        start, sgn, flush, ack;
  logic [31:0] a_i, b_i;
  logic        stall, valid;
  logic [31:0] quo, rmd;

  int checks = 0;
  int fails  = 0;
  logic [63:0] sb[$];

  exe_div_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .resetn(resetn),
    .EXE_DivStart(start), .EXE_DivSigned(sgn),
    .EXE_ResultA(a_i), .EXE_ResultB(b_i),
    .EXE_Flush(flush), .EXE_DivAck(ack),
    .EXE_DivStall(stall), .EXE_DivValid(valid),
    .EXE_DivQuotient(quo), .EXE_DivRemainder(rmd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: on each new result, pop the expected pair and compare.
  logic valid_prev = 1'b0;
  always @(negedge clk) begin
    if (valid && !valid_prev) begin
      checks++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_result: got q=%h r=%h with empty scoreboard", quo, rmd);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        if ({quo, rmd} !== e) begin
          fails++;
          $display("FAIL result: got q=%h r=%h expected q=%h r=%h", quo, rmd, e[63:32], e[31:0]);
        end
      end
    end
    valid_prev = valid;
  end

  // Called just after a rising edge with the DUT idle. chain=1 presents a
  // start together with the final ack (must be ignored; caller re-issues).
  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [31:0] eq, input logic [31:0] er,
                        input int lat, input int hold, input bit chain);
    int n, stall_cnt;
    logic [31:0] q0, r0;
    bit held_ok;
    sb.push_back({eq, er});
    a_i = a; b_i = b; sgn = s; start = 1'b1;
    n = 0; stall_cnt = 0;
    while (!valid && n < 100) begin
      #1;
      if (stall) stall_cnt++;
      @(posedge clk); #1;
      n++;
      start = 1'b0;
      if (n == 5 && !valid) begin
        // stray start mid-operation with different operands
        start = 1'b1; a_i = 32'd55; b_i = 32'd5;
      end
    end
    start = 1'b0; a_i = a; b_i = b;
    chk({name, "_latency"}, 64'(n), 64'(lat));
    chk({name, "_stall_cycles"}, 64'(stall_cnt), 64'(lat));
    q0 = quo; r0 = rmd; held_ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      #1;
      if (!stall) held_ok = 1'b0;
      start = 1'b1; a_i = 32'd1; b_i = 32'd1;
      @(posedge clk); #1;
      start = 1'b0;
      if (!valid || quo !== q0 || rmd !== r0) held_ok = 1'b0;
    end
    if (hold > 0) chk({name, "_hold_stable"}, 64'(held_ok), 64'd1);
    ack = 1'b1;
    if (chain) begin start = 1'b1; a_i = a; b_i = b; sgn = s; end
    #1;
    chk({name, "_stall_on_ack"}, 64'(stall), 64'd0);
    @(posedge clk); #1;
    ack = 1'b0;
    chk({name, "_valid_after_ack"}, 64'(valid), 64'd0);
  endtask

  initial begin
    bit seen;
    resetn = 1'b0; start = 1'b1; sgn = 1'b0; flush = 1'b0; ack = 1'b0;
    a_i = 32'd3; b_i = 32'd1;
    #2;
    chk("reset_outputs", {quo, rmd}, 64'd0);
    chk("reset_valid_stall", {62'd0, valid, stall}, 64'd0);
    start = 1'b0;
    #10 resetn = 1'b1;
    @(posedge clk); #1;

    run_op("divu_100_7",   32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          33, 0, 1'b0);
    run_op("div_m7_2",     32'hFFFFFFF9,   32'd2,          1'b1, 32'hFFFFFFFD,   32'hFFFFFFFF,   33, 0, 1'b0);
    run_op("div_7_m2",     32'd7,          32'hFFFFFFFE,   1'b1, 32'hFFFFFFFD,   32'd1,          33, 0, 1'b0);
    run_op("divu_dbz",     32'h12345678,   32'd0,          1'b0, 32'hFFFFFFFF,   32'h12345678,   1,  0, 1'b0);
    run_op("div_dbz",      32'h12345678,   32'd0,          1'b1, 32'hFFFFFFFF,   32'h12345678,   1,  0, 1'b0);
    run_op("divu_max_2",   32'hFFFFFFFF,   32'd2,          1'b0, 32'h7FFFFFFF,   32'd1,          33, 0, 1'b0);
    run_op("div_ovf",      32'h80000000,   32'hFFFFFFFF,   1'b1, 32'h80000000,   32'd0,          33, 0, 1'b0);
    run_op("divu_min_max", 32'h80000000,   32'hFFFFFFFF,   1'b0, 32'd0,          32'h80000000,   33, 0, 1'b0);
    // Ack withheld 5 cycles, then ack together with a new start.
    run_op("hold_chain",   32'd1000,       32'd33,         1'b0, 32'd30,         32'd10,         33, 5, 1'b1);
    run_op("chained",      32'd1000,       32'd33,         1'b0, 32'd30,         32'd10,         33, 0, 1'b0);

    // Flush at BUSY cycle 10.
    a_i = 32'd100; b_i = 32'd7; sgn = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    chk("flush_idle", {62'd0, valid, stall}, 64'd0);
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (valid || stall) seen = 1'b1; end
    chk("flush_no_valid", 64'(seen), 64'd0);
    run_op("after_flush",  32'd9,          32'd3,          1'b0, 32'd3,          32'd0,          33, 0, 1'b0);

    // Reset between edges mid-BUSY.
    a_i = 32'd100; b_i = 32'd7; sgn = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #2 resetn = 1'b0; start = 1'b1;
    #1;
    chk("midbusy_reset_outputs", {quo, rmd}, 64'd0);
    chk("midbusy_reset_valid_stall", {62'd0, valid, stall}, 64'd0);
    @(negedge clk); resetn = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    chk("post_reset_idle", {62'd0, valid, stall}, 64'd0);
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (valid || stall) seen = 1'b1; end
    chk("post_reset_no_valid", 64'(seen), 64'd0);

    repeat (2) @(posedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
